jk_bank_arb: RTL and testbench

Two-requester controller for a bank of WIDTH JK flip-flops with asynchronous clear. Each requester submits a per-bit J/K vector pair over a valid/ready handshake. A round-robin arbiter serialises the requests, and the bank is updated with standard JK semantics one cycle after acceptance. When the bank is idle it can optionally run as a free-running binary up-counter built from JK toggle terms. The block sits between the control FSMs and the flip-flop state they share.

---
 rtl/jk_bank_pkg.sv | 43 ++++
 rtl/jk_bank_rr_arb.sv | 19 +
 rtl/jk_bank_arb.sv | 131 +++++++++++++
 tb/tb_jk_bank_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
// Shared types, JK op encodings and the next-state helper for the JK bank
// controller. Optional idle counting is enabled by defining JK_BANK_CNT_EN.
package jk_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    // JK ops, encoded as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int JK_MAX_W = 32;

    // Per-bit JK rule at the widest supported bank; callers cast to their width.
    function automatic logic [JK_MAX_W-1:0] jk_next(
        input logic [JK_MAX_W-1:0] q,
        input logic [JK_MAX_W-1:0] j,
        input logic [JK_MAX_W-1:0] k
    );
        logic [JK_MAX_W-1:0] r;
        r = q;
        for (int i = 0; i < JK_MAX_W; i++) begin
            case ({j[i], k[i]})
                JK_HOLD: r[i] = q[i];
                JK_CLR:  r[i] = 1'b0;
                JK_SET:  r[i] = 1'b1;
                JK_TGL:  r[i] = ~q[i];
                default: r[i] = q[i];
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/jk_bank_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// READY is only offered while the owning controller is idle.
module jk_bank_rr_arb
    import jk_bank_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic idle,
    input  req_e last,
    output logic a_ready,
    output logic b_ready,
    output req_e gnt
);

    assign a_ready = idle && a_valid && (!b_valid || (last == REQ_B));
    assign b_ready = idle && b_valid && (!a_valid || (last == REQ_A));
    assign gnt     = b_ready ? REQ_B : REQ_A;

endmodule

// File: rtl/jk_bank_arb.sv
// Two-requester controller for a bank of JK flip-flops. Commands are latched
// on a handshake and applied one cycle later; when idle the bank can count up
// using JK toggle terms (only when JK_BANK_CNT_EN is defined).
//
// state    | meaning
// ST_IDLE  | accepting commands; counting if enabled and no handshake
// ST_APPLY | latched command is written into the bank at the next edge
module jk_bank_arb
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active low
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_j,
    input  logic [WIDTH-1:0] a_k,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_j,
    input  logic [WIDTH-1:0] b_k,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             ack,
    output logic             gnt_b,
    output logic             wrap
);

    state_e           state_q, state_d;
    req_e             last_q, last_d;
    req_e             gnt_b_q, gnt_b_d;
    logic [WIDTH-1:0] cmd_j_q, cmd_j_d;
    logic [WIDTH-1:0] cmd_k_q, cmd_k_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    logic             idle;
    logic             hs;
    req_e             gnt;
    logic [WIDTH-1:0] tgl;
    logic             cnt_go;

    // READY must drop immediately while reset is held, so reset gates idle.
    assign idle = (state_q == ST_IDLE) && reset;

    jk_bank_rr_arb u_arb (
        .a_valid (a_valid),
        .b_valid (b_valid),
        .idle    (idle),
        .last    (last_q),
        .a_ready (a_ready),
        .b_ready (b_ready),
        .gnt     (gnt)
    );

    assign hs = a_ready || b_ready;

    // Counter toggle terms: bit i flips when every lower bit is one.
    assign tgl[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tgl
        assign tgl[i] = &q_q[i-1:0];
    end

`ifdef JK_BANK_CNT_EN
    assign cnt_go = cnt_en;
`else
    logic cnt_en_unused;
    assign cnt_en_unused = cnt_en;
    assign cnt_go        = 1'b0;
`endif

    // Next-state: accept, apply, or count.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_b_d = gnt_b_q;
        cmd_j_d = cmd_j_q;
        cmd_k_d = cmd_k_q;
        q_d     = q_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_APPLY;
                    last_d  = gnt;
                    gnt_b_d = gnt;
                    cmd_j_d = (gnt == REQ_B) ? b_j : a_j;
                    cmd_k_d = (gnt == REQ_B) ? b_k : a_k;
                end else if (cnt_go) begin
                    q_d    = WIDTH'(jk_next(JK_MAX_W'(q_q), JK_MAX_W'(tgl), JK_MAX_W'(tgl)));
                    wrap_d = &q_q;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                q_d     = WIDTH'(jk_next(JK_MAX_W'(q_q), JK_MAX_W'(cmd_j_q), JK_MAX_W'(cmd_k_q)));
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, command and bank registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_B;
            gnt_b_q <= REQ_A;
            cmd_j_q <= '0;
            cmd_k_q <= '0;
            q_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_b_q <= gnt_b_d;
            cmd_j_q <= cmd_j_d;
            cmd_k_q <= cmd_k_d;
            q_q     <= q_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q     = q_q;
    assign qn    = ~q_q;
    assign ack   = (state_q == ST_APPLY);
    assign gnt_b = (gnt_b_q == REQ_B);
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_jk_bank_arb.sv
// Self-checking bench for jk_bank_arb with a transaction-level reference model.
module tb_jk_bank_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_valid, b_valid, cnt_en;
    logic [W-1:0] a_j, a_k, b_j, b_k;
    logic         a_ready, b_ready, ack, gnt_b, wrap;
    logic [W-1:0] q, qn;

    int pass_cnt  = 0;
    int total_cnt = 0;

    jk_bank_arb #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_j     (a_j),
        .a_k     (a_k),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_j     (b_j),
        .b_k     (b_k),
        .cnt_en  (cnt_en),
        .q       (q),
        .qn      (qn),
        .ack     (ack),
        .gnt_b   (gnt_b),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: bank value, whether a command is pending, its owner.
    logic [W-1:0] m_q, m_cj, m_ck;
    bit           m_busy, m_last_b, m_gnt_b, m_wrap;

    // Expectations for the current cycle (sampled between edges).
    logic [W-1:0] e_q;
    bit           e_ar, e_br, e_ack, e_gnt, e_wrap;

    function automatic logic [W-1:0] ref_jk(input logic [W-1:0] qv, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (j[i] && k[i])       r[i] = ~qv[i];
            else if (j[i])          r[i] = 1'b1;
            else if (k[i])          r[i] = 1'b0;
            else                    r[i] = qv[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_q = '0; m_cj = '0; m_ck = '0;
        m_busy = 0; m_last_b = 1; m_gnt_b = 0; m_wrap = 0;
    endtask

    // One cycle: drive at the falling edge, compute this cycle's expectations,
    // then advance the model across the coming rising edge.
    task automatic drive(input bit rst, input bit av, input logic [W-1:0] aj, input logic [W-1:0] ak,
                         input bit bv, input logic [W-1:0] bj, input logic [W-1:0] bk, input bit ce);
        @(negedge clk);
        reset = rst; a_valid = av; a_j = aj; a_k = ak;
        b_valid = bv; b_j = bj; b_k = bk; cnt_en = ce;
        #1;
        if (!rst) model_reset();
        e_q = m_q; e_ack = m_busy; e_gnt = m_gnt_b; e_wrap = m_wrap;
        e_ar = rst && !m_busy && av && (!bv || m_last_b);
        e_br = rst && !m_busy && bv && (!av || !m_last_b);
        if (rst) begin
            m_wrap = 0;
            if (m_busy) begin
                m_q = ref_jk(m_q, m_cj, m_ck);
                m_busy = 0;
            end else if (e_ar || e_br) begin
                m_cj = e_br ? bj : aj;
                m_ck = e_br ? bk : ak;
                m_gnt_b = e_br; m_last_b = e_br; m_busy = 1;
            end else begin
`ifdef JK_BANK_CNT_EN
                if (ce) begin
                    m_wrap = (m_q == {W{1'b1}});
                    m_q = m_q + 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic idle_cyc(input bit ce);
        drive(1, 0, '0, '0, 0, '0, '0, ce);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'hFF, 8'h00, 1, 8'hFF, 8'h00, 1);
            total_cnt++; if (q !== 8'h00) $display("FAIL rst_q got %h want 00", q); else pass_cnt++;
            total_cnt++; if (qn !== 8'hFF) $display("FAIL rst_qn got %h want ff", qn); else pass_cnt++;
            total_cnt++; if (ack !== 1'b0) $display("FAIL rst_ack got %b want 0", ack); else pass_cnt++;
            total_cnt++; if (wrap !== 1'b0) $display("FAIL rst_wrap got %b want 0", wrap); else pass_cnt++;
            total_cnt++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL rst_ready got %b want 00", {a_ready, b_ready}); else pass_cnt++;
            total_cnt++; if (gnt_b !== 1'b0) $display("FAIL rst_gnt got %b want 0", gnt_b); else pass_cnt++;
        end
        drive(1, 1, 8'h00, 8'h00, 0, '0, '0, 0);
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL rst_release_a_ready got %b want 1", a_ready); else pass_cnt++;
        idle_cyc(0);
        idle_cyc(0);
    endtask

    task automatic test_single();
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        drive(1, 1, 8'hF0, 8'h0F, 0, '0, '0, 0);
        total_cnt++; if (a_ready !== 1'b1 || ack !== 1'b0) $display("FAIL single_accept got rdy=%b ack=%b want 1 0", a_ready, ack); else pass_cnt++;
        idle_cyc(0);
        total_cnt++; if (ack !== 1'b1 || q !== 8'h00) $display("FAIL single_apply got ack=%b q=%h want 1 00", ack, q); else pass_cnt++;
        idle_cyc(0);
        total_cnt++; if (q !== 8'hF0) $display("FAIL single_q got %h want f0", q); else pass_cnt++;
        total_cnt++; if (qn !== 8'h0F) $display("FAIL single_qn got %h want 0f", qn); else pass_cnt++;
        total_cnt++; if (gnt_b !== 1'b0 || ack !== 1'b0) $display("FAIL single_gnt got gnt=%b ack=%b want 0 0", gnt_b, ack); else pass_cnt++;
    endtask

    task automatic test_toggle_hold();
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        drive(1, 1, 8'hF0, 8'h0F, 0, '0, '0, 0);
        idle_cyc(0);
        drive(1, 0, '0, '0, 1, 8'hFF, 8'hFF, 0);
        total_cnt++; if (q !== 8'hF0 || b_ready !== 1'b1) $display("FAIL tgl_start got q=%h rdy=%b want f0 1", q, b_ready); else pass_cnt++;
        idle_cyc(0);
        total_cnt++; if (q !== 8'hF0) $display("FAIL tgl_no_early got %h want f0", q); else pass_cnt++;
        drive(1, 0, '0, '0, 1, 8'h00, 8'h00, 0);
        total_cnt++; if (q !== 8'h0F) $display("FAIL tgl_q got %h want 0f", q); else pass_cnt++;
        idle_cyc(0);
        idle_cyc(0);
        total_cnt++; if (q !== 8'h0F || gnt_b !== 1'b1) $display("FAIL hold_q got q=%h gnt=%b want 0f 1", q, gnt_b); else pass_cnt++;
    endtask

    task automatic test_arbitration();
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 8'h11 * i[7:0], 8'h00, 1, 8'h00, 8'h11 * i[7:0], 0);
            if (i % 2 == 0) begin
                total_cnt++;
                if (a_ready !== (i % 4 == 0) || b_ready !== (i % 4 == 2))
                    $display("FAIL arb_grant%0d got a=%b b=%b want a=%b", i, a_ready, b_ready, (i % 4 == 0));
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (a_ready !== 1'b0 || b_ready !== 1'b0 || ack !== 1'b1)
                    $display("FAIL arb_apply%0d got a=%b b=%b ack=%b want 0 0 1", i, a_ready, b_ready, ack);
                else pass_cnt++;
            end
            total_cnt++; if (q !== e_q) $display("FAIL arb_q%0d got %h want %h", i, q, e_q); else pass_cnt++;
        end
    endtask

    task automatic test_counter();
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        drive(1, 1, 8'hFE, 8'h01, 0, '0, '0, 0);
        idle_cyc(0);
        idle_cyc(1);
        total_cnt++; if (q !== 8'hFE) $display("FAIL cnt_load got %h want fe", q); else pass_cnt++;
`ifdef JK_BANK_CNT_EN
        idle_cyc(1);
        total_cnt++; if (q !== 8'hFF || wrap !== 1'b0) $display("FAIL cnt_ff got q=%h wrap=%b want ff 0", q, wrap); else pass_cnt++;
        idle_cyc(1);
        total_cnt++; if (q !== 8'h00 || wrap !== 1'b1) $display("FAIL cnt_wrap got q=%h wrap=%b want 00 1", q, wrap); else pass_cnt++;
        drive(1, 1, 8'h00, 8'h00, 0, '0, '0, 1);
        total_cnt++; if (q !== 8'h01 || wrap !== 1'b0 || a_ready !== 1'b1) $display("FAIL cnt_req got q=%h wrap=%b rdy=%b want 01 0 1", q, wrap, a_ready); else pass_cnt++;
        idle_cyc(1);
        total_cnt++; if (q !== 8'h01 || ack !== 1'b1) $display("FAIL cnt_hold1 got q=%h ack=%b want 01 1", q, ack); else pass_cnt++;
        idle_cyc(1);
        total_cnt++; if (q !== 8'h01) $display("FAIL cnt_hold2 got %h want 01", q); else pass_cnt++;
        idle_cyc(1);
        total_cnt++; if (q !== 8'h02) $display("FAIL cnt_resume got %h want 02", q); else pass_cnt++;
`else
        for (int i = 0; i < 4; i++) begin
            idle_cyc(1);
            total_cnt++; if (q !== 8'hFE || wrap !== 1'b0) $display("FAIL nocnt%0d got q=%h wrap=%b want fe 0", i, q, wrap); else pass_cnt++;
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        drive(1, 1, 8'hFF, 8'h00, 0, '0, '0, 0);
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL rmid_accept got %b want 1", a_ready); else pass_cnt++;
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        total_cnt++; if (q !== 8'h00 || ack !== 1'b0) $display("FAIL rmid_forced got q=%h ack=%b want 00 0", q, ack); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            idle_cyc(0);
            total_cnt++; if (q !== 8'h00 || ack !== 1'b0) $display("FAIL rmid_after%0d got q=%h ack=%b want 00 0", i, q, ack); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        drive(0, 0, '0, '0, 0, '0, '0, 0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6),
                  W'($urandom), W'($urandom), ($urandom_range(0, 9) < 6),
                  W'($urandom), W'($urandom), ($urandom_range(0, 9) < 7));
            total_cnt++;
            if (a_ready !== e_ar || b_ready !== e_br)
                $display("FAIL rnd_ready%0d got %b%b want %b%b", i, a_ready, b_ready, e_ar, e_br);
            else pass_cnt++;
            total_cnt++;
            if (q !== e_q || qn !== ~e_q)
                $display("FAIL rnd_q%0d got q=%h qn=%h want %h", i, q, qn, e_q);
            else pass_cnt++;
            total_cnt++;
            if (ack !== e_ack || gnt_b !== e_gnt || wrap !== e_wrap)
                $display("FAIL rnd_ctl%0d got ack=%b gnt=%b wrap=%b want %b %b %b",
                         i, ack, gnt_b, wrap, e_ack, e_gnt, e_wrap);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b0; a_valid = 0; b_valid = 0; cnt_en = 0;
        a_j = '0; a_k = '0; b_j = '0; b_k = '0;
        model_reset();
        test_reset();
        test_single();
        test_toggle_hold();
        test_arbitration();
        test_counter();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
